sync_fifo_ctrl: RTL and testbench

- Single-clock, parametrised FIFO: storage array plus write/read pointer control, occupancy level, threshold flags and sticky error flags.
- Successor to the bare FIFO storage block: adds its own pointer management, full/empty detection, a registered read port and flush.
- Serves as the intra-domain buffer between same-clock producers and consumers, e.g. ALU result queueing ahead of the UART TX path.

---
 rtl/sync_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with pointer control, occupancy level, threshold and sticky error flags.
// Optional SYNC_FIFO_PARITY_EN stores an even-parity bit per word and reports parity_err on read.
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AFULL_TH   = 6,
   parameter int AEMPTY_TH  = 1
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
`ifdef SYNC_FIFO_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SYNC_FIFO_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef SYNC_FIFO_PARITY_EN
   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
      return ^d;
   endfunction
`endif

   logic [MEM_W-1:0]    mem_r [DEPTH];
   logic [ADDR_WIDTH:0] wptr_r;
   logic [ADDR_WIDTH:0] rptr_r;
   logic [MEM_W-1:0]    wr_word_s;
   logic [MEM_W-1:0]    rd_word_s;
   logic                wa_s;
   logic                ra_s;
   logic                ovf_set_s;
   logic                unf_set_s;

   // Occupancy, flag decode and accept qualification; flush and reset suppress all traffic.
   always_comb begin
      level        = wptr_r - rptr_r;
      full         = (level == DEPTH_L);
      empty        = (level == {(ADDR_WIDTH+1){1'b0}});
      almost_full  = (level >= AFULL_L);
      almost_empty = (level <= AEMPTY_L);
      wa_s         = wr_en & ~full  & ~flush & ~wrst;
      ra_s         = rd_en & ~empty & ~flush & ~wrst;
      ovf_set_s    = wr_en & full  & ~flush & ~wrst;
      unf_set_s    = rd_en & empty & ~flush & ~wrst;
      rd_word_s    = mem_r[rptr_r[ADDR_WIDTH-1:0]];
`ifdef SYNC_FIFO_PARITY_EN
      wr_word_s    = {even_parity(wdata), wdata};
`else
      wr_word_s    = wdata;
`endif
   end

   // Storage write port; contents survive reset and flush.
   always_ff @(posedge wclk) begin
      if (wa_s) begin
         mem_r[wptr_r[ADDR_WIDTH-1:0]] <= wr_word_s;
      end
   end

   // Pointer update: extra MSB distinguishes full from empty and wraps naturally.
   always_ff @(posedge wclk) begin
      if (wrst || flush) begin
         wptr_r <= {(ADDR_WIDTH+1){1'b0}};
         rptr_r <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
         if (wa_s) wptr_r <= wptr_r + PTR_ONE;
         if (ra_s) rptr_r <= rptr_r + PTR_ONE;
      end
   end

   // Registered read port; rdata holds when nothing is popped.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         rdata    <= {DATA_WIDTH{1'b0}};
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= ra_s;
         if (ra_s) rdata <= rd_word_s[DATA_WIDTH-1:0];
      end
   end

   // Sticky error flags; a new error outranks err_clr in the same cycle.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set_s | (overflow  & ~err_clr);
         underflow <= unf_set_s | (underflow & ~err_clr);
      end
   end

`ifdef SYNC_FIFO_PARITY_EN
   // Parity check of the popped word, aligned with rd_valid.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= ra_s & (rd_word_s[DATA_WIDTH] != even_parity(rd_word_s[DATA_WIDTH-1:0]));
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model plus directed literal checks.
module tb_sync_fifo_ctrl;

   logic       wclk = 1'b0;
   logic       wrst = 1'b1;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rdata;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] level;
`ifdef SYNC_FIFO_PARITY_EN
   logic       parity_err;
`endif

   sync_fifo_ctrl dut (
      .wclk(wclk), .wrst(wrst), .flush(flush), .wr_en(wr_en), .wdata(wdata),
      .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`ifdef SYNC_FIFO_PARITY_EN
      , .parity_err(parity_err)
`endif
   );

   always #5 wclk = ~wclk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Inputs as seen by the DUT at the last rising edge
   logic       c_wrst = 1'b1, c_flush = 1'b0, c_wr = 1'b0, c_rd = 1'b0, c_ec = 1'b0;
   logic [7:0] c_wd = 8'h00;
   always @(posedge wclk) begin
      c_wrst  <= wrst;
      c_flush <= flush;
      c_wr    <= wr_en;
      c_rd    <= rd_en;
      c_ec    <= err_clr;
      c_wd    <= wdata;
   end

   // Reference model: a queue of stored words, advanced once per cycle, then compared
   logic [7:0] q[$];
   logic [7:0] m_rdata = 8'h00;
   logic       m_rv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   initial begin
      forever begin
         @(negedge wclk);
         if (c_wrst) begin
            q.delete();
            m_rdata = 8'h00; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         end else if (c_flush) begin
            q.delete();
            m_rv = 1'b0;
         end else begin
            int n;
            n = q.size();
            m_rv = 1'b0;
            if (c_rd && n > 0) begin
               m_rdata = q.pop_front();
               m_rv = 1'b1;
            end
            if (c_wr && n < 8) q.push_back(c_wd);
            m_ovf = (c_wr && n == 8) || (m_ovf && !c_ec);
            m_unf = (c_rd && n == 0) || (m_unf && !c_ec);
         end
         check("m_level", level, q.size());
         check("m_empty", empty, q.size() == 0);
         check("m_full", full, q.size() == 8);
         check("m_afull", almost_full, q.size() >= 6);
         check("m_aempty", almost_empty, q.size() <= 1);
         check("m_rd_valid", rd_valid, m_rv);
         check("m_rdata", rdata, m_rdata);
         check("m_overflow", overflow, m_ovf);
         check("m_underflow", underflow, m_unf);
      end
   end

   // Apply one cycle of inputs, return after the edge has taken effect
   task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic ec, input logic rs);
      wr_en = wr; wdata = d; rd_en = rd; flush = fl; err_clr = ec; wrst = rs;
      @(negedge wclk);
   endtask

   initial begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_aempty", almost_empty, 1'b1);
      check("rst_afull", almost_full, 1'b0);
      check("rst_level", level, 4'd0);

      // Basic ordering
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t1_rd0", rdata, 8'h11);
      check("t1_rv0", rd_valid, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t1_rd1", rdata, 8'h22);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t1_rd2", rdata, 8'h33);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_rv_end", rd_valid, 1'b0);
      check("t1_empty", empty, 1'b1);

      // Fill to full, overflow, drain in order
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         check("t2_afull", almost_full, (i + 1) >= 6);
      end
      check("t2_full", full, 1'b1);
      check("t2_level", level, 4'd8);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_ovf", overflow, 1'b1);
      check("t2_level_ovf", level, 4'd8);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         check("t2_rd", rdata, 8'h40 + 8'(i));
      end
      check("t2_empty", empty, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t2_ovf_clr", overflow, 1'b0);

      // Streaming at level 4 across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
         check("t3_rd", rdata, (i < 4) ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 4));
         check("t3_level", level, 4'd4);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t3_last", rdata, 8'hA3);
      check("t3_noerr", {overflow, underflow}, 2'b00);

      // Underflow and err_clr priority
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t4_unf", underflow, 1'b1);
      check("t4_rv", rd_valid, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t4_unf_clr", underflow, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t4_unf_win", underflow, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Flush with a concurrent write, then reset mid-stream
      for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5_fl_level", level, 4'd0);
      check("t5_fl_empty", empty, 1'b1);
      check("t5_fl_rdata", rdata, 8'hA3);
      for (int i = 0; i < 5; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_pre_rst", rdata, 8'hD0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_rst_level", level, 4'd0);
      check("t5_rst_rdata", rdata, 8'h00);
      check("t5_rst_rv", rd_valid, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_post", rdata, 8'h77);

`ifdef SYNC_FIFO_PARITY_EN
      // Corrupt the stored parity of one entry
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      dut.mem_r[0][8] = ~dut.mem_r[0][8];
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("tp_bad_rd", rdata, 8'hA5);
      check("tp_bad_perr", {rd_valid, parity_err}, 2'b11);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("tp_good_rd", rdata, 8'h3C);
      check("tp_good_perr", {rd_valid, parity_err}, 2'b10);
`endif

      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
